// File: rtl/hdr_gain_reconstructor_if.sv
// hdr_gain_reconstructor_if: sample-in / linear-sample-out bus of the gain reconstructor
interface hdr_gain_reconstructor_if #(
  parameter int DATA_W = 9,
  parameter int OUT_W  = 13
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_sample;
  logic                     alpha;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  out_sample;
  logic                     out_alpha;
  logic                     settling;
  logic [7:0]               switch_count;
  modport master (
    output in_valid, in_sample, alpha,
    input  out_valid, out_sample, out_alpha, settling, switch_count
  );
  modport slave (
    input  in_valid, in_sample, alpha,
    output out_valid, out_sample, out_alpha, settling, switch_count
  );
endinterface

// File: rtl/hdr_gain_reconstructor.sv
// hdr_gain_reconstructor: aligns alpha to the analog latency, undoes front-end gain, holds output while settling
module hdr_gain_reconstructor #(
  parameter int DATA_W         = 9,
  parameter int GAIN_SHIFT     = 4,
  parameter int OUT_W          = 13,
  parameter int ALPHA_DELAY    = 3,
  parameter int SETTLE_SAMPLES = 2
) (
  input logic                      clk,
  input logic                      reset,
  hdr_gain_reconstructor_if.slave  bus
);
  typedef enum logic {STEADY, SETTLE} state_t;
  localparam logic [3:0] RELOAD = 4'(SETTLE_SAMPLES - 1);
  state_t                  state;
  logic [3:0]              cnt;
  logic                    g, g_prev, chg, hold;
  logic signed [OUT_W-1:0] s, lin, held;
  generate
    if (ALPHA_DELAY == 0) begin : g_nodelay
      assign g = bus.alpha;
    end else begin : g_delay
      logic [ALPHA_DELAY-1:0] dl;
      always_ff @(posedge clk)
        if (!reset) dl <= '1;
        else if (bus.in_valid) dl <= (dl << 1) | ALPHA_DELAY'(bus.alpha);
      assign g = dl[ALPHA_DELAY-1];
    end
  endgenerate
  always_comb begin
    s    = OUT_W'(bus.in_sample);
    lin  = g ? s <<< GAIN_SHIFT : s;
    chg  = g != g_prev;
    hold = (state == SETTLE) ? (chg || cnt != 4'd0) : (chg && SETTLE_SAMPLES > 0);
  end
  // held only ever captures live samples, so a hold always replays the last good-gain value
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.out_valid    <= 1'b0;
      bus.out_sample   <= '0;
      bus.out_alpha    <= 1'b1;
      bus.settling     <= 1'b0;
      bus.switch_count <= 8'd0;
      g_prev           <= 1'b1;
      held             <= '0;
      state            <= STEADY;
      cnt              <= 4'd0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.out_alpha  <= g;
        g_prev         <= g;
        bus.settling   <= hold;
        bus.out_sample <= hold ? held : lin;
        if (!hold) held <= lin;
        if (chg && bus.switch_count != 8'hFF) bus.switch_count <= bus.switch_count + 8'd1;
        if (chg && SETTLE_SAMPLES > 1) begin
          state <= SETTLE;
          cnt   <= RELOAD;
        end else if (state == SETTLE) begin
          if (cnt == 4'd0) state <= STEADY;
          else cnt <= cnt - 4'd1;
        end
      end
    end
  end
endmodule
